// File: rtl/ram_arbiter_if.sv
// Bus bundle between the CPU, video and SDRAM-controller sides and ram_arbiter.
// The slave view is the arbiter; the master view is its environment.
interface ram_arbiter_if #(
    parameter int AW = 24
);
    logic          cpuRq;
    logic          cpuWe;
    logic [AW-1:0] cpuA;
    logic [7:0]    cpuD;
    logic [7:0]    cpuQ;
    logic          cpuAck;

    logic          vidRq;
    logic [AW-1:0] vidA;
    logic [15:0]   vidQ;
    logic          vidAck;

    logic          memRq;
    logic          memRf;
    logic          memWe;
    logic [AW-1:0] memA;
    logic [7:0]    memD;
    logic [15:0]   memQ;
    logic          memAck;

    modport slave (
        input  cpuRq, cpuWe, cpuA, cpuD,
        output cpuQ, cpuAck,
        input  vidRq, vidA,
        output vidQ, vidAck,
        output memRq, memRf, memWe, memA, memD,
        input  memQ, memAck
    );

    modport master (
        output cpuRq, cpuWe, cpuA, cpuD,
        input  cpuQ, cpuAck,
        output vidRq, vidA,
        input  vidQ, vidAck,
        input  memRq, memRf, memWe, memA, memD,
        output memQ, memAck
    );
endinterface

// File: rtl/ram_arbiter.sv
// Arbitrates CPU, video and periodic refresh onto one SDRAM controller command port.
// Optional command watchdog with sticky err output: define RAM_ARBITER_WATCHDOG_EN.
module ram_arbiter #(
    parameter int AW   = 24,
    parameter int RFSH = 187,
    parameter int RMAX = 4
) (
    input  logic         clock,
    input  logic         reset,
    ram_arbiter_if.slave bus,
    output logic         busy
`ifdef RAM_ARBITER_WATCHDOG_EN
    ,
    output logic         err
`endif
);
    localparam int CW = (RFSH > 1) ? $clog2(RFSH) : 1;
    localparam int DW = $clog2(RMAX + 1);
    localparam logic [AW-1:0] RF_ADDR = '0;

    typedef enum logic { IDLE, WAIT } state_t;
    typedef enum logic [1:0] { OWN_CPU, OWN_VID, OWN_RF } owner_t;

    state_t        state;
    owner_t        owner;
    owner_t        grant_who;
    logic          grant;
    logic          grant_rf;
    logic          wrap;
    logic          urgent;
    logic [CW-1:0] rf_cnt;
    logic [DW-1:0] debt;
`ifdef RAM_ARBITER_WATCHDOG_EN
    logic [8:0]    wd;
`endif

    assign wrap     = (rf_cnt == CW'(RFSH - 1));
    assign urgent   = (debt == DW'(RMAX));
    assign grant_rf = grant && (grant_who == OWN_RF);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant     = 1'b0;
        grant_who = OWN_RF;
        if (state == IDLE) begin
            // A requester whose ack is showing this cycle still holds its line; skip it.
            if (urgent) begin
                grant = 1'b1;
            end else if (bus.vidRq && !bus.vidAck) begin
                grant     = 1'b1;
                grant_who = OWN_VID;
            end else if (bus.cpuRq && !bus.cpuAck) begin
                grant     = 1'b1;
                grant_who = OWN_CPU;
            end else if (debt != '0) begin
                grant = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_RF;
            rf_cnt     <= '0;
            debt       <= '0;
            busy       <= 1'b0;
            bus.memRq  <= 1'b0;
            bus.memRf  <= 1'b0;
            bus.memWe  <= 1'b0;
            bus.memA   <= '0;
            bus.memD   <= '0;
            bus.cpuAck <= 1'b0;
            bus.vidAck <= 1'b0;
            bus.cpuQ   <= '0;
            bus.vidQ   <= '0;
`ifdef RAM_ARBITER_WATCHDOG_EN
            wd         <= '0;
            err        <= 1'b0;
`endif
        end else begin
            bus.memRq  <= 1'b0;
            bus.cpuAck <= 1'b0;
            bus.vidAck <= 1'b0;
            rf_cnt     <= wrap ? '0 : rf_cnt + CW'(1);

            // A wrap and a refresh grant in the same cycle cancel out.
            if (wrap && !grant_rf && !urgent) begin
                debt <= debt + DW'(1);
            end else if (!wrap && grant_rf) begin
                debt <= debt - DW'(1);
            end

            case (state)
                IDLE: begin
                    if (grant) begin
                        state     <= WAIT;
                        busy      <= 1'b1;
                        owner     <= grant_who;
                        bus.memRq <= 1'b1;
`ifdef RAM_ARBITER_WATCHDOG_EN
                        wd        <= '0;
`endif
                        if (grant_who == OWN_CPU) begin
                            bus.memA  <= bus.cpuA;
                            bus.memWe <= bus.cpuWe;
                            bus.memD  <= bus.cpuD;
                            bus.memRf <= 1'b0;
                        end else if (grant_who == OWN_VID) begin
                            bus.memA  <= bus.vidA;
                            bus.memWe <= 1'b0;
                            bus.memD  <= '0;
                            bus.memRf <= 1'b0;
                        end else begin
                            bus.memA  <= RF_ADDR;
                            bus.memWe <= 1'b0;
                            bus.memD  <= '0;
                            bus.memRf <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.memAck) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (owner == OWN_CPU) begin
                            bus.cpuAck <= 1'b1;
                            // Byte lane chosen by the address bit latched at grant.
                            if (!bus.memWe) begin
                                bus.cpuQ <= bus.memA[0] ? bus.memQ[15:8] : bus.memQ[7:0];
                            end
                        end else if (owner == OWN_VID) begin
                            bus.vidAck <= 1'b1;
                            bus.vidQ   <= bus.memQ;
                        end
                    end
`ifdef RAM_ARBITER_WATCHDOG_EN
                    else if (wd == 9'd255) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        wd <= wd + 9'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with a cycle-level reference model
// and a behavioural SDRAM controller with random completion latency.
module tb_ram_arbiter;
    localparam int AW   = 24;
    localparam int RFSH = 8;
    localparam int RMAX = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic busy;
`ifdef RAM_ARBITER_WATCHDOG_EN
    logic err;
`endif

    ram_arbiter_if #(.AW(AW)) bus ();

    ram_arbiter #(.AW(AW), .RFSH(RFSH), .RMAX(RMAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
`ifdef RAM_ARBITER_WATCHDOG_EN
        ,
        .err   (err)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic       hold_ack  = 1'b0;
    logic       stray_req = 1'b0;
    logic [7:0] cpu_last  = '0;
    logic [7:0]  cpu_exp[$];
    logic [15:0] vid_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Contents the controller returns for a given word address.
    function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
        if (a == 24'h000011) return 16'hA55A;
        return {a[7:0] ^ 8'h3C, a[15:8] ^ a[23:16] ^ 8'hC3};
    endfunction

    task automatic cpu_txn(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                           input bit keep, output time t_ack);
        logic [15:0] w;
        int n;
        w = mem_word(a);
        if (!we) cpu_last = a[0] ? w[15:8] : w[7:0];
        cpu_exp.push_back(cpu_last);
        bus.cpuWe = we;
        bus.cpuA  = a;
        bus.cpuD  = d;
        bus.cpuRq = 1'b1;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (!bus.cpuAck && n < 1000);
        check("cpu_ack_seen", 32'(bus.cpuAck), 32'd1);
        t_ack = $time;
        if (!keep) bus.cpuRq = 1'b0;
    endtask

    task automatic vid_txn(input logic [AW-1:0] a, input bit keep, output time t_ack);
        int n;
        vid_exp.push_back(mem_word(a));
        bus.vidA  = a;
        bus.vidRq = 1'b1;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (!bus.vidAck && n < 1000);
        check("vid_ack_seen", 32'(bus.vidAck), 32'd1);
        t_ack = $time;
        if (!keep) bus.vidRq = 1'b0;
    endtask

    // SDRAM controller: completes each command after 0..3 extra cycles.
    initial begin : controller
        bit pend;
        int lat;
        logic [AW-1:0] pa;
        pend = 1'b0;
        lat  = 0;
        pa   = '0;
        bus.memAck = 1'b0;
        bus.memQ   = '0;
        forever begin
            @(posedge clock); #1;
            bus.memAck = 1'b0;
            bus.memQ   = 16'($urandom);
            if (!reset) begin
                pend = 1'b0;
            end else begin
                if (bus.memRq) begin
                    pend = 1'b1;
                    pa   = bus.memA;
                    lat  = $urandom_range(0, 3);
                end
                if (pend && !hold_ack) begin
                    if (lat == 0) begin
                        bus.memAck = 1'b1;
                        bus.memQ   = mem_word(pa);
                        pend       = 1'b0;
                    end else begin
                        lat--;
                    end
                end else if (!pend && stray_req && !busy && !bus.memRq) begin
                    bus.memAck = 1'b1;
                end
            end
        end
    end

    // Reference model and monitor: predicts each edge's outcome from the arbitration rules.
    initial begin : monitor
        int m_cnt, m_debt, m_owner, m_wd, win;
        bit m_busy, m_rq, m_cack, m_vack, m_err, wrap, g, n_rq, n_cack, n_vack;
        logic [AW-1:0] m_addr;
        logic m_we;
        logic [7:0] m_d, hold_cpu;
        logic [15:0] hold_vid;
        forever begin
            @(negedge clock);
            if (!reset) begin
                m_cnt = 0; m_debt = 0; m_owner = 0; m_wd = 0;
                m_busy = 0; m_rq = 0; m_cack = 0; m_vack = 0; m_err = 0;
                m_addr = '0; m_we = 0; m_d = '0; hold_cpu = '0; hold_vid = '0;
                check("rst_memRq", 32'(bus.memRq), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_cpuAck", 32'(bus.cpuAck), 0);
                check("rst_vidAck", 32'(bus.vidAck), 0);
                check("rst_memA", 32'(bus.memA), 0);
                check("rst_cpuQ", 32'(bus.cpuQ), 0);
                check("rst_vidQ", 32'(bus.vidQ), 0);
                continue;
            end
            check("memRq", 32'(bus.memRq), 32'(m_rq));
            check("busy", 32'(busy), 32'(m_busy));
            check("cpuAck", 32'(bus.cpuAck), 32'(m_cack));
            check("vidAck", 32'(bus.vidAck), 32'(m_vack));
`ifdef RAM_ARBITER_WATCHDOG_EN
            check("err", 32'(err), 32'(m_err));
`endif
            if (m_busy) begin
                check("memRf", 32'(bus.memRf), 32'(m_owner == 2));
                if (m_owner != 2) begin
                    check("memA", 32'(bus.memA), 32'(m_addr));
                    check("memWe", 32'(bus.memWe), 32'(m_we));
                    if (m_we) check("memD", 32'(bus.memD), 32'(m_d));
                end
            end
            if (bus.cpuAck) begin
                check("cpu_ack_expected", 32'(cpu_exp.size() != 0), 1);
                if (cpu_exp.size() != 0) hold_cpu = cpu_exp.pop_front();
            end
            if (bus.vidAck) begin
                check("vid_ack_expected", 32'(vid_exp.size() != 0), 1);
                if (vid_exp.size() != 0) hold_vid = vid_exp.pop_front();
            end
            check("cpuQ", 32'(bus.cpuQ), 32'(hold_cpu));
            check("vidQ", 32'(bus.vidQ), 32'(hold_vid));

            wrap  = (m_cnt == RFSH - 1);
            m_cnt = (m_cnt + 1) % RFSH;
            g = 0; n_rq = 0; n_cack = 0; n_vack = 0;
            if (m_busy) begin
                if (bus.memAck) begin
                    m_busy = 0;
                    n_cack = (m_owner == 0);
                    n_vack = (m_owner == 1);
                end
`ifdef RAM_ARBITER_WATCHDOG_EN
                else if (m_wd == 255) begin
                    m_busy = 0;
                    m_err  = 1;
                end else begin
                    m_wd++;
                end
`endif
            end else begin
                win = -1;
                if (m_debt == RMAX) win = 2;
                else if (bus.vidRq && !m_vack) win = 1;
                else if (bus.cpuRq && !m_cack) win = 0;
                else if (m_debt > 0) win = 2;
                if (win >= 0) begin
                    m_busy = 1; n_rq = 1; m_owner = win; m_wd = 0;
                    g = (win == 2);
                    m_addr = (win == 0) ? bus.cpuA : bus.vidA;
                    m_we   = (win == 0) ? bus.cpuWe : 1'b0;
                    m_d    = bus.cpuD;
                end
            end
            m_debt = m_debt - int'(g) + int'(wrap);
            if (m_debt > RMAX) m_debt = RMAX;
            m_rq = n_rq; m_cack = n_cack; m_vack = n_vack;
        end
    end

    initial begin : stimulus
        time t1, t_c, t_v;
        int nrf, nrq, nacks, n;
        bus.cpuRq = 1'b0; bus.cpuWe = 1'b0; bus.cpuA = '0; bus.cpuD = '0;
        bus.vidRq = 1'b0; bus.vidA = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        cpu_txn(1'b0, 24'h000011, 8'h00, 1'b0, t1);
        repeat (2) begin @(posedge clock); #1; end

        fork
            cpu_txn(1'b0, 24'h000200, 8'h00, 1'b0, t_c);
            vid_txn(24'h800300, 1'b0, t_v);
        join
        check("contention_video_first", 32'(t_v < t_c), 1);

        fork
            begin
                int gc;
                repeat (40) begin
                    gc = $urandom_range(0, 3);
                    cpu_txn(1'($urandom_range(0, 1)), AW'($urandom), 8'($urandom), gc == 0, t1);
                    repeat (gc) begin @(posedge clock); #1; end
                end
                bus.cpuRq = 1'b0;
            end
            begin
                int gv;
                repeat (40) begin
                    gv = $urandom_range(0, 3);
                    vid_txn(AW'($urandom), gv == 0, t_v);
                    repeat (gv) begin @(posedge clock); #1; end
                end
                bus.vidRq = 1'b0;
            end
        join

        repeat (60) begin @(posedge clock); #1; end
        nrf = 0; nrq = 0;
        repeat (80) begin
            @(posedge clock); #1;
            if (bus.memRq) nrq++;
            if (bus.memRq && bus.memRf) nrf++;
        end
        check("quiet_refresh_count", nrf, 10);
        check("quiet_memRq_count", nrq, 10);

        repeat (20) vid_txn(AW'($urandom), 1'b1, t_v);
        bus.vidRq = 1'b0;
        repeat (3) begin @(posedge clock); #1; end

        hold_ack  = 1'b1;
        bus.cpuWe = 1'b0;
        bus.cpuA  = 24'h000123;
        bus.cpuRq = 1'b1;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (!busy && n < 50);
        check("wait_entered", 32'(busy), 1);
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("rstwait_memRq", 32'(bus.memRq), 0);
        check("rstwait_memRf", 32'(bus.memRf), 0);
        check("rstwait_memWe", 32'(bus.memWe), 0);
        check("rstwait_memA", 32'(bus.memA), 0);
        check("rstwait_memD", 32'(bus.memD), 0);
        check("rstwait_busy", 32'(busy), 0);
        check("rstwait_cpuAck", 32'(bus.cpuAck), 0);
        check("rstwait_vidAck", 32'(bus.vidAck), 0);
        bus.cpuRq = 1'b0;
        hold_ack  = 1'b0;
        cpu_last  = '0;
        @(posedge clock);
        #1 reset = 1'b1;
        stray_req = 1'b1;
        nacks = 0;
        repeat (10) begin
            @(posedge clock); #1;
            if (bus.cpuAck || bus.vidAck) nacks++;
        end
        stray_req = 1'b0;
        check("stray_ack_ignored", nacks, 0);

`ifdef RAM_ARBITER_WATCHDOG_EN
        hold_ack = 1'b1;
        fork
            cpu_txn(1'b0, 24'h000456, 8'h00, 1'b0, t1);
            begin
                n = 0;
                do begin @(posedge clock); #1; n++; end while (!err && n < 600);
                check("wd_err_set", 32'(err), 1);
                check("wd_busy_clear", 32'(busy), 0);
                hold_ack = 1'b0;
            end
        join
`endif

        repeat (10) begin @(posedge clock); #1; end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, 24: word-address width of all address ports.
REQ-002 Parameter RFSH, 187: refresh interval in clock cycles (7.8 us at 24 MHz).
REQ-003 Parameter RMAX, 4: maximum refresh debt before refresh becomes urgent.
REQ-004 clock  in  1  system clock; every register is on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cpuRq  in  1  CPU request level, held until cpuAck.
REQ-007 cpuWe  in  1  CPU write (1) or read (0), sampled at grant.
REQ-008 cpuA  in  AW  CPU address, sampled at grant.
REQ-009 cpuD  in  8  CPU write data, sampled at grant.
REQ-010 cpuQ  out  8  CPU read data, valid when cpuAck=1.
REQ-011 cpuAck  out  1  one-cycle completion pulse for the CPU.
REQ-012 vidRq  in  1  video read request level, held until vidAck.
REQ-013 vidA  in  AW  video address, sampled at grant.
REQ-014 vidQ  out  16  video read data, valid when vidAck=1.
REQ-015 vidAck  out  1  one-cycle completion pulse for video.
REQ-016 memRq  out  1  one-cycle command strobe to the SDRAM controller.
REQ-017 memRf  out  1  refresh command, qualifies memRq.
REQ-018 memWe  out  1  write command, qualifies memRq.
REQ-019 memA  out  AW  command address.
REQ-020 memD  out  8  command write data.
REQ-021 memQ  in  16  controller read data, valid with memAck.
REQ-022 memAck  in  1  controller completion pulse.
REQ-023 busy  out  1  high while a command is outstanding.
REQ-024 err  out  1  sticky watchdog error flag; exists only when the watchdog is compiled in.

Function
REQ-025 States: IDLE and WAIT.
- IDLE: memRq is issued in the same cycle as the grant decision.
- Entering WAIT sets busy=1.
- WAIT -> IDLE on memAck=1.
REQ-026 Grant priority in IDLE, highest first:
- refresh urgent (debt=RMAX)
- vidRq
- cpuRq
- refresh pending (debt>0)
REQ-027 memA, memWe, memD and memRf are registered at grant and held stable until memAck.
REQ-028 Refresh counter:
- counts 0..RFSH-1 and wraps.
- on wrap, debt increments, saturating at RMAX; no further increment while at RMAX.
REQ-029 A granted refresh decrements debt by one at grant; a wrap in the same cycle nets to no change.
REQ-030 memAck for a CPU command: cpuAck=1 for exactly one cycle.
- If the command was a read, cpuQ=memQ[7:0] when cpuA[0]=0, otherwise memQ[15:8], using the address latched at grant.
REQ-031 memAck for a video command: vidAck=1 for one cycle and vidQ=memQ.
- memAck for a refresh produces no requester ack.
REQ-032 Timing:
- Minimum request-to-memRq latency is 1 cycle (request seen in IDLE, strobe the next edge).
- Ack is issued the cycle after memAck.
- Back-to-back: a new grant may occur the cycle after the ack.
REQ-033 A requester is never granted twice without an intervening ack.
- A request line still high in the cycle its ack is issued is not regranted in that cycle.
REQ-034 memAck received in IDLE is ignored.
REQ-035 cpuQ and vidQ hold their last value between acks.

Reset
REQ-036 Asserting reset, at any time including in WAIT, forces the following:
- state=IDLE
- counter=0, debt=0
- memRq=memRf=memWe=0
- memA=0, memD=0
- cpuAck=vidAck=0, cpuQ=0, vidQ=0
- busy=0, err=0
REQ-037 The first grant may occur one cycle after reset deasserts.

Configuration
REQ-038 Macro RAM_ARBITER_WATCHDOG_EN defined:
- a 9-bit counter runs in WAIT.
- after 256 cycles without memAck: return to IDLE, set err=1 (sticky until reset), issue no requester ack.
- the same requester is regranted later.
REQ-039 Macro RAM_ARBITER_WATCHDOG_EN undefined: no watchdog logic, err port absent, WAIT is exited only by memAck.

Verification
REQ-040 Read: cpuRq=1, cpuWe=0, cpuA=0x000011, controller returns memQ=0xA55A -> memRq one cycle with memA=0x000011, then cpuAck with cpuQ=0xA5.
REQ-041 Contention: cpuRq and vidRq rise in the same cycle -> video granted first and vidAck issued; CPU granted on the next IDLE cycle.
REQ-042 Refresh: RFSH=8, no requests -> memRq with memRf=1 every 8 cycles.
- RFSH=8, vidRq held high -> refresh is preempted until debt=4, then refresh wins over video.
REQ-043 Wrap during grant: refresh grant in the same cycle as a counter wrap -> debt unchanged.
REQ-044 Reset in WAIT: reset low while busy=1 -> all outputs at reset values; a later stray memAck produces no ack.
REQ-045 Watchdog, RAM_ARBITER_WATCHDOG_EN defined: memAck withheld -> err=1 after 256 cycles, busy=0, and the pending request is regranted.
